// File: rtl/gf_square_iter.sv
// gf_square_iter -- sequential GF(2^m) repeated squarer.
//
// Computes result = A^(2^k) mod P(x), with one squaring and reduction per clock.
// It serves the ECC datapath (Itoh-Tsujii inversion chains, Frobenius maps).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   a_in/k_in valid (sampled only in IDLE)
//   in_ready   unit can accept an operand (registered)
//   a_in       operand A, polynomial basis, must be < 2^m
//   k_in       number of squarings k
//   out_valid  result valid, held until out_ready (registered)
//   out_ready  consumer accepts result
//   result     A^(2^k) mod P (registered)
//   abort      present only when GF_SQ_ABORT_EN is defined; drops a RUN/DONE operation
//
// Build option: define GF_SQ_ABORT_EN to add the abort input.
module gf_square_iter #(
    parameter int                  NUM_BITS = 163,
    parameter logic [NUM_BITS-1:0] POLY     = NUM_BITS'(8'hC9),
    parameter int                  CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] a_in,
    input  logic [CNT_W-1:0]    k_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] result
`ifdef GF_SQ_ABORT_EN
    ,
    input  logic                abort
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int              SW   = 2*NUM_BITS - 1;
    localparam logic [SW-1:0]   SPOLY = {{(NUM_BITS-1){1'b0}}, POLY};
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t              state_q;
    logic [NUM_BITS-1:0] acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [NUM_BITS-1:0] sq_acc;

    // Square by bit interleaving, then fold the high half down from the top.
    // Folding bit j adds POLY at offset j-m, which only touches bits below j,
    // so a single downward pass reduces fully for any POLY.
    function automatic logic [NUM_BITS-1:0] sq_mod(input logic [NUM_BITS-1:0] a);
        logic [SW-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_BITS; i++) s[2*i] = a[i];
        for (int j = SW-1; j >= NUM_BITS; j--) begin
            if (s[j]) begin
                s    = s ^ (SPOLY << (j - NUM_BITS));
                s[j] = 1'b0;
            end
        end
        return s[NUM_BITS-1:0];
    endfunction

    assign sq_acc = sq_mod(acc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end
`ifdef GF_SQ_ABORT_EN
        else if (abort && state_q != S_IDLE) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end
`endif
        else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        acc_q      <= a_in;
                        cnt_q      <= k_in;
                        in_ready_q <= 1'b0;
                        if (k_in != '0) begin
                            state_q <= S_RUN;
                        end else begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= sq_acc;
                    cnt_q <= cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Handoff cycle; accepting again waits for the IDLE cycle.
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    // acc is itself a register and equals the final value whenever DONE.
    assign result    = acc_q;

endmodule

// File: tb/tb_gf_square_iter.sv
module tb_gf_square_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready;
    logic         in_ready, out_valid;
    logic [162:0] a_in, result;
    logic [7:0]   k_in;

    logic         in_valid4, out_ready4, in_ready4, out_valid4;
    logic [3:0]   a4, result4;
    logic [7:0]   k4;
`ifdef GF_SQ_ABORT_EN
    logic         abort;
`endif

    always #5 clk = ~clk;

    gf_square_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .k_in(k_in), .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
`ifdef GF_SQ_ABORT_EN
        , .abort(abort)
`endif
    );

    gf_square_iter #(.NUM_BITS(4), .POLY(4'h3), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a_in(a4), .k_in(k4), .out_valid(out_valid4), .out_ready(out_ready4),
        .result(result4)
`ifdef GF_SQ_ABORT_EN
        , .abort(1'b0)
`endif
    );

    localparam logic [255:0] P163 = 256'hC9;
    localparam logic [255:0] P4   = 256'h3;

    int n_chk = 0;
    int n_fail = 0;
    logic [255:0] sb[$];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: schoolbook multiply with per-step reduction (MSB-first).
    function automatic logic [255:0] gmul(input logic [255:0] a, input logic [255:0] b,
                                          input logic [255:0] poly, input int m);
        logic [255:0] r;
        r = '0;
        for (int i = m-1; i >= 0; i--) begin
            r = r << 1;
            if (r[m]) begin
                r[m] = 1'b0;
                r = r ^ poly;
            end
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [255:0] gpow(input logic [255:0] a, input int k,
                                          input logic [255:0] poly, input int m);
        logic [255:0] e;
        e = a;
        for (int i = 0; i < k; i++) e = gmul(e, e, poly, m);
        return e;
    endfunction

    function automatic logic [162:0] rnd163();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[162:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int lim, output int n);
        n = 0;
        while (!out_valid && n < lim) begin
            tick();
            n++;
        end
    endtask

    // Full transaction on the 163-bit unit: accept, latency, result, optional
    // stall in DONE, handoff, and IDLE on the following cycle.
    task automatic run_op(input string tag, input logic [162:0] a, input int k,
                          input int stall, output logic [162:0] res);
        logic [255:0] e;
        int n, g;
        g = 0;
        while (!in_ready && g < 400) begin tick(); g++; end
        chk({tag, "_rdy"}, {255'd0, in_ready}, 256'd1);
        in_valid = 1'b1; a_in = a; k_in = 8'(k);
        sb.push_back(gpow({93'd0, a}, k, P163, 163));
        tick();
        in_valid = 1'b0;
        wait_out(k + 20, n);
        chk({tag, "_lat"}, n, k);
        e = sb.pop_front();
        res = result;
        if (!out_valid) begin
            chk({tag, "_timeout"}, 256'd0, 256'd1);
        end else begin
            chk({tag, "_res"}, {93'd0, result}, e);
            for (int i = 0; i < stall; i++) begin
                tick();
                chk({tag, "_hold_res"}, {93'd0, result}, e);
                chk({tag, "_hold_ordy"}, {254'd0, out_valid, in_ready}, 256'd2);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({tag, "_idle"}, {254'd0, out_valid, in_ready}, 256'd1);
        end
    endtask

    initial begin
        logic [162:0] a, r;
        logic [255:0] e;
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; k_in = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; k4 = '0;
`ifdef GF_SQ_ABORT_EN
        abort = 1'b0;
`endif
        tick(); tick();
        chk("rst_ordy", {254'd0, out_valid, in_ready}, 256'd1);
        chk("rst_res", {93'd0, result}, 256'd0);
        chk("rst4_ordy", {254'd0, out_valid4, in_ready4}, 256'd1);
        chk("rst4_res", {252'd0, result4}, 256'd0);
        rst = 1'b0;
        tick();

        // Small field: x^(2^3) = x^8 = x^2 + 1 mod x^4+x+1.
        in_valid4 = 1'b1; a4 = 4'h2; k4 = 8'd3;
        sb.push_back(gpow(256'h2, 3, P4, 4));
        tick();
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 20) begin tick(); n++; end
        chk("f4_lat", n, 3);
        e = sb.pop_front();
        chk("f4_res_model", {252'd0, result4}, e);
        chk("f4_res_const", {252'd0, result4}, 256'h5);
        out_ready4 = 1'b1; tick(); out_ready4 = 1'b0;
        chk("f4_idle", {254'd0, out_valid4, in_ready4}, 256'd1);

        // x^200 reduced in B-163.
        a = '0; a[100] = 1'b1;
        run_op("b163_x100", a, 1, 0, r);
        e = '0; e[44] = 1'b1; e[43] = 1'b1; e[40] = 1'b1; e[37] = 1'b1;
        chk("b163_x100_const", {93'd0, r}, e);

        a = rnd163();
        run_op("k0", a, 0, 0, r);
        chk("k0_ident", {93'd0, r}, {93'd0, a});

        a = rnd163();
        run_op("frob", a, 163, 0, r);
        chk("frob_ident", {93'd0, r}, {93'd0, a});

        run_op("stall", rnd163(), 5, 10, r);
        run_op("kmax", rnd163(), 255, 0, r);
        run_op("rnd7", rnd163(), 7, 1, r);

        // in_valid during RUN must not disturb the running operation.
        a = rnd163();
        in_valid = 1'b1; a_in = a; k_in = 8'd4;
        sb.push_back(gpow({93'd0, a}, 4, P163, 163));
        tick();
        a_in = ~a; k_in = 8'd1;
        tick(); tick();
        in_valid = 1'b0;
        n = 2;
        while (!out_valid && n < 30) begin tick(); n++; end
        chk("ign_lat", n, 4);
        e = sb.pop_front();
        chk("ign_res", {93'd0, result}, e);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("ign_idle", {254'd0, out_valid, in_ready}, 256'd1);

        // Reset in the middle of a k=20 run.
        in_valid = 1'b1; a_in = rnd163(); k_in = 8'd20;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ordy", {254'd0, out_valid, in_ready}, 256'd1);
        chk("midrst_res", {93'd0, result}, 256'd0);
        tick(); tick();
        chk("midrst_quiet", {254'd0, out_valid, in_ready}, 256'd1);

`ifdef GF_SQ_ABORT_EN
        in_valid = 1'b1; a_in = rnd163(); k_in = 8'd20;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ordy", {254'd0, out_valid, in_ready}, 256'd1);
        chk("abort_res", {93'd0, result}, 256'd0);
        run_op("post_abort", rnd163(), 3, 0, r);
`endif

        run_op("after_rst", rnd163(), 2, 0, r);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
